// File: rtl/regfile_pkg.sv
// Shared defaults and the write-address delay-line stage record for reg_file_pipe.
package regfile_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;
  // Stage records carry a fixed-width address field; sizes up to 256 registers fit.
  localparam int unsigned AW_MAX    = 8;

  function automatic int unsigned addr_width(input int unsigned nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

  typedef struct packed {
    logic              valid;
    logic [AW_MAX-1:0] addr;
  } stage_t;

endpackage

// File: rtl/reg_file_wa_delay.sv
// Valid/address shift line carrying issued write destinations to commit, with stall and flush.
module reg_file_wa_delay
  import regfile_pkg::*;
#(
  parameter int unsigned AW    = 5,
  parameter int unsigned DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                flush,
  input  logic                in_v,
  input  logic [AW-1:0]       in_a,
  output stage_t [DEPTH-1:0]  stages
);

  stage_t [DEPTH-1:0] stage_q;
  stage_t [DEPTH-1:0] stage_d;

  // Flush clears valids even while stalled; addresses left behind are don't-care.
  always_comb begin
    stage_d = stage_q;
    if (!stall) begin
      stage_d[0].valid = in_v;
      stage_d[0].addr  = AW_MAX'(in_a);
      for (int unsigned s = 1; s < DEPTH; s++) begin
        stage_d[s] = stage_q[s-1];
      end
    end
    if (flush) begin
      for (int unsigned s = 0; s < DEPTH; s++) begin
        stage_d[s].valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign stages = stage_q;

endmodule

// File: rtl/reg_file_pipe.sv
// Multi-port register file with delayed write address, write-to-read bypass and hazard flags.
module reg_file_pipe
  import regfile_pkg::*;
#(
  parameter  int unsigned XLEN     = XLEN_DEF,
  parameter  int unsigned NREGS    = NREGS_DEF,
  parameter  int unsigned NRD      = 2,
  parameter  int unsigned WA_DELAY = 2,
  parameter  int unsigned BYPASS   = 1,
  parameter  int unsigned ZERO_REG = 1,
  localparam int unsigned AW       = addr_width(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wa_v,
  input  logic [AW-1:0]     wa,
  input  logic              stall,
  input  logic              flush,
  input  logic              we,
  input  logic [XLEN-1:0]   wd,
  input  logic [NRD*AW-1:0] ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]    hazard
);

  localparam int unsigned NSTG = (WA_DELAY > 0) ? WA_DELAY : 1;

  stage_t [NSTG-1:0] stages;
  logic              commit_v;
  logic [AW-1:0]     commit_a;
  logic              commit;
  logic [XLEN-1:0]   regs_q [NREGS];

  if (WA_DELAY == 0) begin : g_nodelay
    assign stages   = '0;
    assign commit_v = wa_v;
    assign commit_a = wa;
  end else begin : g_delay
    reg_file_wa_delay #(
      .AW    (AW),
      .DEPTH (WA_DELAY)
    ) u_wa_delay (
      .clk    (clk),
      .rst    (rst),
      .stall  (stall),
      .flush  (flush),
      .in_v   (wa_v),
      .in_a   (wa),
      .stages (stages)
    );
    assign commit_v = stages[WA_DELAY-1].valid;
    assign commit_a = stages[WA_DELAY-1].addr[AW-1:0];
  end

  assign commit = we && commit_v && !stall && !((ZERO_REG != 0) && (commit_a == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (commit) begin
      regs_q[commit_a] <= wd;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_port
    logic [AW-1:0]   ra_p;
    logic            is_zero;
    logic [XLEN-1:0] rd_p;
    logic            hit;

    assign ra_p    = ra[p*AW +: AW];
    assign is_zero = (ZERO_REG != 0) && (ra_p == '0);

    always_comb begin
      rd_p = regs_q[ra_p];
      if (is_zero) begin
        rd_p = '0;
      end else if ((BYPASS != 0) && commit && (ra_p == commit_a)) begin
        rd_p = wd;
      end
    end

    // A final-stage write being forwarded this cycle is no longer a hazard.
    always_comb begin
      hit = 1'b0;
      if (!is_zero) begin
        for (int unsigned s = 0; s < WA_DELAY; s++) begin
          if (stages[s].valid && (stages[s].addr == AW_MAX'(ra_p)) &&
              !((s == WA_DELAY - 1) && (BYPASS != 0) && commit)) begin
            hit = 1'b1;
          end
        end
      end
    end

    assign rd[p*XLEN +: XLEN] = rd_p;
    assign hazard[p]          = hit;
  end

endmodule

// File: tb/tb_reg_file_pipe.sv
// Self-checking bench for reg_file_pipe: directed vector table, corner sequences, random vs model.
module tb_reg_file_pipe;

  localparam int unsigned XL = 32;
  localparam int unsigned AWB = 5;
  localparam int unsigned NR = 2;
  localparam int unsigned WD = 2;

  logic             clk;
  logic             rst;
  logic             wa_v;
  logic [AWB-1:0]   wa;
  logic             stall;
  logic             flush;
  logic             we;
  logic [XL-1:0]    wd;
  logic [AWB-1:0]   ra0;
  logic [AWB-1:0]   ra1;
  logic [NR*AWB-1:0] ra;
  logic [NR*XL-1:0] rd;
  logic [NR-1:0]    hazard;
  logic [NR*XL-1:0] rd_nb;
  logic [NR-1:0]    hazard_nb;

  int tests;
  int fails;

  assign ra = {ra1, ra0};

  reg_file_pipe #(
    .XLEN(32), .NREGS(32), .NRD(2), .WA_DELAY(2), .BYPASS(1), .ZERO_REG(1)
  ) u_dut (
    .clk(clk), .rst(rst), .wa_v(wa_v), .wa(wa), .stall(stall), .flush(flush),
    .we(we), .wd(wd), .ra(ra), .rd(rd), .hazard(hazard)
  );

  reg_file_pipe #(
    .XLEN(32), .NREGS(32), .NRD(2), .WA_DELAY(2), .BYPASS(0), .ZERO_REG(1)
  ) u_nb (
    .clk(clk), .rst(rst), .wa_v(wa_v), .wa(wa), .stall(stall), .flush(flush),
    .we(we), .wd(wd), .ra(ra), .rd(rd_nb), .hazard(hazard_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural registers plus the in-flight destination list.
  logic [XL-1:0]  m_regs [32];
  logic           m_v [WD];
  logic [AWB-1:0] m_a [WD];

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    for (int s = 0; s < WD; s++) begin
      m_v[s] = 1'b0;
      m_a[s] = '0;
    end
  endtask

  function automatic logic m_commit();
    return we && m_v[WD-1] && !stall && (m_a[WD-1] != 0);
  endfunction

  function automatic logic [XL-1:0] m_rd(input logic [AWB-1:0] a);
    if (a == 0) return '0;
    if (m_commit() && a == m_a[WD-1]) return wd;
    return m_regs[a];
  endfunction

  function automatic logic m_hz(input logic [AWB-1:0] a);
    logic h;
    h = 1'b0;
    if (a != 0) begin
      for (int s = 0; s < WD; s++) begin
        if (m_v[s] && m_a[s] == a && !(s == WD - 1 && m_commit())) h = 1'b1;
      end
    end
    return h;
  endfunction

  task automatic chk(input string nm, input logic [XL-1:0] act, input logic [XL-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    chk($sformatf("%s rd0", tag), rd[0 +: XL], m_rd(ra0));
    chk($sformatf("%s rd1", tag), rd[XL +: XL], m_rd(ra1));
    chk($sformatf("%s hz0", tag), XL'(hazard[0]), XL'(m_hz(ra0)));
    chk($sformatf("%s hz1", tag), XL'(hazard[1]), XL'(m_hz(ra1)));
  endtask

  // Advance one clock, updating the model with the inputs held across the edge.
  task automatic clock_edge();
    logic           c;
    logic [AWB-1:0] ca;
    logic [XL-1:0]  cd;
    logic           st, fl, nv;
    logic [AWB-1:0] na;
    c  = m_commit();
    ca = m_a[WD-1];
    cd = wd;
    st = stall;
    fl = flush;
    nv = wa_v;
    na = wa;
    @(posedge clk);
    if (c) m_regs[ca] = cd;
    if (!st) begin
      for (int s = WD - 1; s > 0; s--) begin
        m_v[s] = m_v[s-1];
        m_a[s] = m_a[s-1];
      end
      m_v[0] = nv;
      m_a[0] = na;
    end
    if (fl) for (int s = 0; s < WD; s++) m_v[s] = 1'b0;
    #1;
  endtask

  task automatic set_in(input logic v, input logic [AWB-1:0] a, input logic s, input logic f,
                        input logic w, input logic [XL-1:0] d);
    wa_v  = v;
    wa    = a;
    stall = s;
    flush = f;
    we    = w;
    wd    = d;
  endtask

  typedef struct {
    logic           v;
    logic [AWB-1:0] a;
    logic           w;
    logic [XL-1:0]  d;
    logic [AWB-1:0] r0;
    logic [AWB-1:0] r1;
    logic [XL-1:0]  e_rd0;
    logic [XL-1:0]  e_rd1;
    logic [1:0]     e_hz;
    logic [XL-1:0]  e_nb0;
    logic [XL-1:0]  e_nb1;
  } vec_t;

  vec_t vecs [6];

  initial begin
    tests = 0;
    fails = 0;
    set_in(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    ra0 = 5'd5;
    ra1 = 5'd7;
    rst = 1'b1;
    model_reset();
    #2;
    chk("reset rd0", rd[0 +: XL], 32'h0);
    chk("reset hazard", XL'(hazard), 32'h0);
    #10 rst = 1'b0;
    @(posedge clk);
    #1;

    // Delayed write to x5, bypass of x7, suppressed commit to x0.
    vecs[0] = '{1'b1, 5'd5, 1'b0, 32'h0,        5'd5, 5'd7, 32'h0,        32'h0,        2'b00, 32'h0, 32'h0};
    vecs[1] = '{1'b1, 5'd7, 1'b0, 32'h0,        5'd5, 5'd7, 32'h0,        32'h0,        2'b01, 32'h0, 32'h0};
    vecs[2] = '{1'b1, 5'd0, 1'b1, 32'h1234,     5'd5, 5'd7, 32'h1234,     32'h0,        2'b10, 32'h0, 32'h0};
    vecs[3] = '{1'b0, 5'd0, 1'b1, 32'hA5A5A5A5, 5'd7, 5'd5, 32'hA5A5A5A5, 32'h1234,     2'b00, 32'h0, 32'h1234};
    vecs[4] = '{1'b0, 5'd0, 1'b1, 32'hFFFFFFFF, 5'd0, 5'd7, 32'h0,        32'hA5A5A5A5, 2'b00, 32'h0, 32'hA5A5A5A5};
    vecs[5] = '{1'b0, 5'd0, 1'b0, 32'h0,        5'd0, 5'd5, 32'h0,        32'h1234,     2'b00, 32'h0, 32'h1234};
    for (int i = 0; i < 6; i++) begin
      set_in(vecs[i].v, vecs[i].a, 1'b0, 1'b0, vecs[i].w, vecs[i].d);
      ra0 = vecs[i].r0;
      ra1 = vecs[i].r1;
      #2;
      chk($sformatf("vec%0d rd0", i), rd[0 +: XL], vecs[i].e_rd0);
      chk($sformatf("vec%0d rd1", i), rd[XL +: XL], vecs[i].e_rd1);
      chk($sformatf("vec%0d hazard", i), XL'(hazard), XL'(vecs[i].e_hz));
      chk($sformatf("vec%0d nobypass rd0", i), rd_nb[0 +: XL], vecs[i].e_nb0);
      chk($sformatf("vec%0d nobypass rd1", i), rd_nb[XL +: XL], vecs[i].e_nb1);
      clock_edge();
    end

    // Mid-cycle reset discards both register contents and an in-flight write.
    set_in(1'b1, 5'd9, 1'b0, 1'b0, 1'b0, '0);
    ra0 = 5'd5;
    ra1 = 5'd9;
    #2;
    check_model("pre-reset");
    clock_edge();
    set_in(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    #2;
    chk("pre-reset x5", rd[0 +: XL], 32'h1234);
    chk("pre-reset hz x9", XL'(hazard[1]), 32'h1);
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    model_reset();
    chk("async reset x5", rd[0 +: XL], 32'h0);
    chk("async reset hazard", XL'(hazard), 32'h0);
    clock_edge();

    // Stall holds the pending x3 write; flush under stall cancels it.
    ra0 = 5'd3;
    ra1 = 5'd3;
    set_in(1'b1, 5'd3, 1'b0, 1'b0, 1'b0, '0);
    #2; check_model("stl issue"); clock_edge();
    set_in(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    #2; check_model("stl move"); clock_edge();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, '0, 1'b1, 1'b0, 1'b1, 32'h3333);
      #2;
      check_model($sformatf("stall%0d", i));
      chk($sformatf("stall%0d x3", i), rd[0 +: XL], 32'h0);
      chk($sformatf("stall%0d hz", i), XL'(hazard), 32'h3);
      clock_edge();
    end
    set_in(1'b0, '0, 1'b1, 1'b1, 1'b1, 32'h3333);
    #2; check_model("flush"); clock_edge();
    set_in(1'b0, '0, 1'b0, 1'b0, 1'b1, 32'h3333);
    #2;
    check_model("post-flush");
    chk("post-flush hz", XL'(hazard), 32'h0);
    chk("post-flush x3", rd[0 +: XL], 32'h0);
    clock_edge();
    set_in(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    #2;
    chk("x3 never written", rd[XL +: XL], 32'h0);

    // Back-to-back duplicate destinations: later write wins.
    ra0 = 5'd9;
    ra1 = 5'd9;
    set_in(1'b1, 5'd9, 1'b0, 1'b0, 1'b0, '0);
    #2; check_model("dup0"); clock_edge();
    set_in(1'b1, 5'd9, 1'b0, 1'b0, 1'b0, '0);
    #2; check_model("dup1"); clock_edge();
    set_in(1'b0, '0, 1'b0, 1'b0, 1'b1, 32'h1);
    #2; check_model("dup2"); clock_edge();
    set_in(1'b0, '0, 1'b0, 1'b0, 1'b1, 32'h2);
    #2; check_model("dup3"); clock_edge();
    set_in(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    #2;
    chk("dup x9 port0", rd[0 +: XL], 32'h2);
    chk("dup x9 port1", rd[XL +: XL], 32'h2);
    clock_edge();

    // Random traffic on a narrow address range to provoke collisions.
    for (int i = 0; i < 400; i++) begin
      set_in(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
             1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 9) == 0),
             1'($urandom_range(0, 3) != 0), 32'($urandom));
      ra0 = 5'($urandom_range(0, 7));
      ra1 = ($urandom_range(0, 3) == 0) ? ra0 : 5'($urandom_range(0, 7));
      #2;
      check_model($sformatf("rand%0d", i));
      clock_edge();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
